intersection_scheduler: RTL and testbench
=========================================

# intersection_scheduler

Round-robin scheduler that shares one intersection between `N_APPROACH` approaches. At most one approach is green at any time. It serves vehicle-sensor requests with minimum and maximum green times, a fixed yellow, and an all-red clearance interval. An emergency preempt can steal the right of way. It sits above the per-approach signal heads and drives every head's R/G/Y lines.

## Interface
- `N_APPROACH`, default 4: number of approaches; must be ≥2.
- `MIN_GREEN`, default 5: minimum green cycles; must be ≥1.
- `MAX_GREEN`, default 15: green cycles after which a waiting approach forces a change; must be ≥`MIN_GREEN`.
- `YELLOW_TIME`, default 2: exact yellow cycles; must be ≥1.
- `ALLRED_TIME`, default 1: minimum all-red clearance cycles; must be ≥1.
- `CW`, default 8: phase counter width; every time parameter must be < 2^`CW`.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req`  in  `N_APPROACH`: level vehicle-presence request, one bit per approach.
- `emerg`  in  1: level emergency preempt.
- `emerg_id`  in  clog2(`N_APPROACH`): approach to preempt toward; sampled only while `emerg`=1.
- `lights`  out  3·`N_APPROACH`: `lights[3i+2:3i]` = {R,G,Y} of approach i; 100 = red, 010 = green, 001 = yellow.
- `grant_id`  out  clog2(`N_APPROACH`): approach currently or last granted.
- `phase`  out  2: 00 = ALL_RED, 01 = GREEN, 10 = YELLOW.

## Operation
- **Reset** sets: state ALL_RED, counter 0, `grant_id` 0, round-robin pointer 0, every light field 100, `phase` 00.
- **Counter:** clears to 0 on every state change and otherwise increments. It saturates at its terminal value when the state is held.
- **"Other pending"** means `req` with the `grant_id` bit masked off.
- **ALL_RED state:**
  - All lights are 100.
  - When counter ≥ `ALLRED_TIME`−1, select a winner:
    - If `emerg`=1, the winner is `emerg_id`.
    - Otherwise, the winner is the first set `req` bit searching from the pointer upward, with wrap-around.
  - On a winner: set `grant_id` to the winner and go to GREEN.
  - With no `req` and no `emerg`, remain in ALL_RED indefinitely.
- **GREEN state:**
  - The granted approach shows 010; all others show 100.
  - Go to YELLOW when any of the following holds:
    - (a) `emerg`=1 and `emerg_id`≠`grant_id`. This happens immediately, ignoring `MIN_GREEN`.
    - (b) `emerg`=0, counter ≥ `MIN_GREEN`−1, and other pending≠0.
    - (c) `emerg`=0 and counter ≥ `MAX_GREEN`−1 with other pending≠0. This case is covered by (b); it is listed for clarity.
  - With no other pending, rest on green with no limit.
  - `emerg` toward the granted approach holds green regardless of `req`.
- **YELLOW state:**
  - The granted approach shows 001; all others show 100.
  - After exactly `YELLOW_TIME` cycles, go to ALL_RED and set the pointer to (`grant_id`+1) mod `N_APPROACH`.
  - Yellow is never shortened or extended, including by `emerg`.
- `req` is not latched; a request dropped before the decision cycle is not served.
- A granted approach whose `req` drops keeps green until another approach requests.

## Timing
- All outputs are registered and change on the same edge as the state register.
- A decision made in cycle t (counter at its terminal value) shows on the outputs in cycle t+1.
- Green lasts ≥`MIN_GREEN` cycles unless preempted, and is preempted within 1 cycle of `emerg`.
- Yellow lasts exactly `YELLOW_TIME` cycles; all-red lasts ≥`ALLRED_TIME` cycles.
- No two approaches are ever non-red in the same cycle.
- There is never a direct GREEN→GREEN or YELLOW→GREEN transition; every change passes through ALL_RED.
- **Reset mid-operation:** outputs go to the reset values asynchronously and the next phase starts as after power-up.
- An out-of-range `emerg_id` (≥`N_APPROACH`) is ignored, so `emerg` is treated as 0.

## Structure
- Shared package `traffic_pkg` holds:
  - the phase enum ALL_RED/GREEN/YELLOW (2 bits, encodings as above);
  - light constants `LIGHT_RED`=3'b100, `LIGHT_GREEN`=3'b010, `LIGHT_YELLOW`=3'b001.
- One sub-module, `rr_pick`: combinational round-robin search.
  - Inputs: request vector and pointer.
  - Outputs: valid flag and index.
- The FSM, counter and light decode stay in `intersection_scheduler`.

## Test plan
- **Idle after reset:** reset, then `req`=0 for 30 cycles → `lights` all 100, `phase`=00, `grant_id`=0 throughout.
- **Single request rests on green:** hold `req`=0001 → approach 0 shows 010 from the cycle after ALL_RED ends, and stays 010 for 40 cycles, past `MAX_GREEN`.
- **Two-way alternation:** hold `req`=0011 → repeating pattern:
  - approach 0 green 5 cycles, yellow 2, all-red 1;
  - approach 1 green 5, yellow 2, all-red 1;
  - repeat.
- **Four-way fairness:** hold `req`=1111 → `grant_id` sequence 0,1,2,3,0,1; never two non-red fields in one cycle.
- **Preempt:** approach 0 in its 2nd green cycle, assert `emerg`=1, `emerg_id`=2 →
  - approach 0 yellow next cycle for 2 cycles, then all-red 1 cycle;
  - approach 2 green, held past 15 cycles while `emerg`=1 with `req`=1111.
- **Reset mid-yellow:** assert `reset` during yellow → all lights 100 and `grant_id`=0 immediately; after release with `req`=0100, approach 2 is granted after `ALLRED_TIME`.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection signal controller: phase encoding
// and the {R,G,Y} light patterns driven onto each approach's signal head.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'b00,
    GREEN   = 2'b01,
    YELLOW  = 2'b10
  } phase_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_GREEN  = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b001;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above the pointer,
// wrapping around to the lowest set request when nothing above it is pending.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0] lo_mask;
  logic [N-1:0] hi_req;

  assign lo_mask = ({{(N-1){1'b0}}, 1'b1} << ptr) - {{(N-1){1'b0}}, 1'b1};
  assign hi_req  = req & ~lo_mask;
  assign valid   = |req;

  // Descending scans leave the lowest set bit; the upper-half scan overrides the wrapped one.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
    if (|hi_req) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (hi_req[i]) idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Round-robin intersection scheduler: one approach at a time goes
// GREEN -> YELLOW -> ALL_RED, with min/max green and emergency preemption.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int N_APPROACH  = 4,
  parameter int MIN_GREEN   = 5,
  parameter int MAX_GREEN   = 15,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int CW          = 8,
  localparam int IW         = $clog2(N_APPROACH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_APPROACH-1:0]   req,
  input  logic                    emerg,
  input  logic [IW-1:0]           emerg_id,
  output logic [3*N_APPROACH-1:0] lights,
  output logic [IW-1:0]           grant_id,
  output logic [1:0]              phase
);

  localparam int NID = 1 << IW;

  phase_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n, term;
  logic [CW:0]             cnt_p1;
  logic [IW-1:0]           ptr, ptr_n, grant_n;
  logic [N_APPROACH-1:0]   other_pending;
  logic [NID-1:0]          id_in_range;
  logic                    emerg_v;
  logic                    pick_valid;
  logic [IW-1:0]           pick_idx;
  logic [3*N_APPROACH-1:0] lights_n;

  rr_pick #(
    .N  (N_APPROACH),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // An emergency toward a nonexistent approach is treated as no emergency at all.
  always_comb begin
    id_in_range = '0;
    for (int i = 0; i < N_APPROACH; i++) id_in_range[i] = 1'b1;
  end

  assign emerg_v       = emerg & id_in_range[emerg_id];
  assign other_pending = req & ~({{(N_APPROACH-1){1'b0}}, 1'b1} << grant_id);
  assign cnt_p1        = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};

  always_comb begin
    state_n = state;
    grant_n = grant_id;
    ptr_n   = ptr;
    term    = '0;
    case (state)
      ALL_RED: begin
        term = CW'(ALLRED_TIME - 1);
        if (cnt_p1 >= (CW+1)'(ALLRED_TIME)) begin
          if (emerg_v) begin
            grant_n = emerg_id;
            state_n = GREEN;
          end else if (pick_valid) begin
            grant_n = pick_idx;
            state_n = GREEN;
          end
        end
      end
      GREEN: begin
        term = CW'(MAX_GREEN - 1);
        if (emerg_v) begin
          if (emerg_id != grant_id) state_n = YELLOW;
        end else if (cnt_p1 >= (CW+1)'(MIN_GREEN) && |other_pending) begin
          state_n = YELLOW;
        end
      end
      YELLOW: begin
        term = CW'(YELLOW_TIME - 1);
        if (cnt_p1 >= (CW+1)'(YELLOW_TIME)) begin
          state_n = ALL_RED;
          ptr_n   = (grant_id == IW'(N_APPROACH - 1)) ? '0 : grant_id + 1'b1;
        end
      end
      default: state_n = ALL_RED;
    endcase

    if (state_n != state) cnt_n = '0;
    else if (cnt < term)  cnt_n = cnt + 1'b1;
    else                  cnt_n = cnt;
  end

  // Lights are decoded from the next state so they switch on the same edge as the FSM.
  always_comb begin
    lights_n = {N_APPROACH{LIGHT_RED}};
    for (int i = 0; i < N_APPROACH; i++) begin
      if (IW'(i) == grant_n) begin
        if (state_n == GREEN)       lights_n[3*i +: 3] = LIGHT_GREEN;
        else if (state_n == YELLOW) lights_n[3*i +: 3] = LIGHT_YELLOW;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ALL_RED;
      cnt      <= '0;
      grant_id <= '0;
      ptr      <= '0;
      lights   <= {N_APPROACH{LIGHT_RED}};
      phase    <= ALL_RED;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      grant_id <= grant_n;
      ptr      <= ptr_n;
      lights   <= lights_n;
      phase    <= state_n;
    end
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench for intersection_scheduler: per-cycle expectations are
// queued with each stimulus and compared one cycle later against the outputs.
module tb_intersection_scheduler;

  localparam logic [1:0] PH_AR = 2'b00;
  localparam logic [1:0] PH_G  = 2'b01;
  localparam logic [1:0] PH_Y  = 2'b10;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic        emerg;
  logic [1:0]  emerg_id;
  logic [11:0] lights;
  logic [1:0]  grant_id;
  logic [1:0]  phase;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [1:0] ph;
    logic [1:0] gr;
    string      name;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       emerg;
    logic [1:0] eid;
    int         rep;
    logic [1:0] ph;
    logic [1:0] gr;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl [0:17];

  intersection_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .emerg    (emerg),
    .emerg_id (emerg_id),
    .lights   (lights),
    .grant_id (grant_id),
    .phase    (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] expLights(input logic [1:0] ph, input logic [1:0] gr);
    logic [11:0] l;
    l = 12'b100_100_100_100;
    for (int i = 0; i < 4; i++) begin
      if (gr == 2'(i) && ph == PH_G) l[3*i +: 3] = 3'b010;
      if (gr == 2'(i) && ph == PH_Y) l[3*i +: 3] = 3'b001;
    end
    return l;
  endfunction

  task automatic checkOutput();
    exp_t        e;
    logic [11:0] el;
    n_compared++;
    if (sbq.size() == 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard: got empty queue want an entry");
      return;
    end
    e  = sbq.pop_front();
    el = expLights(e.ph, e.gr);
    if (lights !== el) begin
      n_mismatched++;
      $display("[TB] FAIL %s lights: got %b want %b at %0t", e.name, lights, el, $time);
    end
    n_compared++;
    if (phase !== e.ph) begin
      n_mismatched++;
      $display("[TB] FAIL %s phase: got %b want %b at %0t", e.name, phase, e.ph, $time);
    end
    n_compared++;
    if (grant_id !== e.gr) begin
      n_mismatched++;
      $display("[TB] FAIL %s grant_id: got %0d want %0d at %0t", e.name, grant_id, e.gr, $time);
    end
  endtask

  // Called at a falling edge; the expectation is checked just after the next rising edge.
  task automatic applyStimulus(input logic [3:0] r, input logic e, input logic [1:0] id,
                               input logic [1:0] ph, input logic [1:0] gr, input string nm);
    exp_t x;
    req      = r;
    emerg    = e;
    emerg_id = id;
    x.ph = ph;
    x.gr = gr;
    x.name = nm;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic doReset();
    exp_t x;
    reset    = 1'b1;
    req      = '0;
    emerg    = 1'b0;
    emerg_id = '0;
    #1;
    x.ph = PH_AR;
    x.gr = 2'd0;
    x.name = "reset";
    sbq.push_back(x);
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] ph;
    int         p;
    exp_t       x;

    tbl[0]  = '{1'b1, 4'b0001, 1'b0, 2'd0, 1,  PH_G,  2'd0};
    tbl[1]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 5,  PH_G,  2'd0};
    tbl[2]  = '{1'b0, 4'b0010, 1'b0, 2'd0, 2,  PH_Y,  2'd0};
    tbl[3]  = '{1'b0, 4'b0010, 1'b0, 2'd0, 1,  PH_AR, 2'd0};
    tbl[4]  = '{1'b0, 4'b0010, 1'b0, 2'd0, 1,  PH_G,  2'd1};
    tbl[5]  = '{1'b1, 4'b1111, 1'b0, 2'd0, 2,  PH_G,  2'd0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 2'd2, 2,  PH_Y,  2'd0};
    tbl[7]  = '{1'b0, 4'b1111, 1'b1, 2'd2, 1,  PH_AR, 2'd0};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 2'd2, 20, PH_G,  2'd2};
    tbl[9]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 2,  PH_Y,  2'd2};
    tbl[10] = '{1'b0, 4'b1111, 1'b0, 2'd0, 1,  PH_AR, 2'd2};
    tbl[11] = '{1'b0, 4'b1111, 1'b0, 2'd0, 1,  PH_G,  2'd3};
    tbl[12] = '{1'b1, 4'b0000, 1'b1, 2'd3, 1,  PH_G,  2'd3};
    tbl[13] = '{1'b0, 4'b0001, 1'b1, 2'd1, 2,  PH_Y,  2'd3};
    tbl[14] = '{1'b0, 4'b0001, 1'b1, 2'd1, 1,  PH_AR, 2'd3};
    tbl[15] = '{1'b0, 4'b0001, 1'b1, 2'd1, 1,  PH_G,  2'd1};
    tbl[16] = '{1'b0, 4'b0001, 1'b0, 2'd0, 3,  PH_G,  2'd1};
    tbl[17] = '{1'b0, 4'b0011, 1'b0, 2'd0, 1,  PH_G,  2'd1};

    reset    = 1'b0;
    req      = '0;
    emerg    = 1'b0;
    emerg_id = '0;
    @(negedge clk);

    $display("[TB] idle after reset");
    doReset();
    for (int c = 0; c < 30; c++) applyStimulus(4'b0000, 1'b0, 2'd0, PH_AR, 2'd0, "idle");

    $display("[TB] single request rests on green");
    doReset();
    for (int c = 0; c < 41; c++) applyStimulus(4'b0001, 1'b0, 2'd0, PH_G, 2'd0, "single");

    // Green 5, yellow 2, all-red 1 per approach, rotating through the requesters.
    for (int k = 2; k <= 4; k += 2) begin
      $display("[TB] %0d-way rotation", k);
      doReset();
      for (int c = 1; c <= 12 * k; c++) begin
        p  = (c - 1) % 8;
        ph = (p < 5) ? PH_G : (p < 7) ? PH_Y : PH_AR;
        applyStimulus((k == 2) ? 4'b0011 : 4'b1111, 1'b0, 2'd0, ph,
                      2'(((c - 1) / 8) % k), (k == 2) ? "two_way" : "four_way");
      end
    end

    $display("[TB] table sequences");
    for (int v = 0; v < 18; v++) begin
      if (tbl[v].rst) doReset();
      for (int r = 0; r < tbl[v].rep; r++)
        applyStimulus(tbl[v].req, tbl[v].emerg, tbl[v].eid, tbl[v].ph, tbl[v].gr, $sformatf("vec%0d", v));
    end

    $display("[TB] reset mid-yellow");
    doReset();
    for (int c = 0; c < 5; c++) applyStimulus(4'b0011, 1'b0, 2'd0, PH_G, 2'd0, "pre_yellow");
    applyStimulus(4'b0011, 1'b0, 2'd0, PH_Y, 2'd0, "pre_yellow");
    #2;
    reset = 1'b1;
    #1;
    x.ph = PH_AR;
    x.gr = 2'd0;
    x.name = "async_reset";
    sbq.push_back(x);
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(4'b0100, 1'b0, 2'd0, PH_G, 2'd2, "after_reset");
    applyStimulus(4'b0100, 1'b0, 2'd0, PH_G, 2'd2, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
